// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// State encoding plus the wrapping increment used for the round-robin pointer.
package uart_tx_arbiter_pkg;

   localparam int UART_W = 8;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Zero latency; no backpressure, pure function of req and ptr.
module uart_tx_arbiter_rr_picker
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [2*NUM_REQ-1:0] req_dbl;
   logic                 found;

   // Doubling the vector turns the wrap-around search into a linear scan from ptr.
   always_comb begin
      req_dbl = {req, req};
      idx     = '0;
      found   = 1'b0;
      for (int j = 0; j < 2 * NUM_REQ; j++) begin
         if (!found && (j >= int'(ptr)) && req_dbl[j]) begin
            found = 1'b1;
            idx   = IDX_W'((j >= NUM_REQ) ? j - NUM_REQ : j);
         end
      end
   end

   always_comb begin
      any    = found;
      onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         onehot[i] = found && (idx == IDX_W'(i));
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one UART transmitter between NUM_REQ byte streams.
// One idle cycle of arbitration per message; req_ready of the holder follows tx_ready combinationally.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int TIMEOUT_WIDTH  = 20
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [UART_W*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [UART_W-1:0]         tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      timeout_pulse
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
   localparam logic [TIMEOUT_WIDTH-1:0] CNT_LIMIT =
      TIMEOUT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_e                   state_q, state_d;
   logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]         gidx_q, gidx_d;
   logic [NUM_REQ-1:0]       grant_q, grant_d;
   logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
   logic                     timeout_pulse_q, timeout_pulse_d;

   logic [NUM_REQ-1:0] pick_onehot;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;

   logic               g_valid;
   logic               g_last;
   logic [UART_W-1:0]  g_data;
   logic               stall_expired;
   logic [IDX_W-1:0]   next_ptr;

   uart_tx_arbiter_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req    (req_valid),
      .ptr    (rr_ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // grant_q is one-hot (or zero), so the holder's signals reduce to AND-OR.
   always_comb begin
      g_valid = |(req_valid & grant_q);
      g_last  = |(req_last & grant_q);
      g_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            g_data = req_data[i*UART_W +: UART_W];
         end
      end
   end

   always_comb begin
      next_ptr      = IDX_W'(wrap_inc(int'(gidx_q), NUM_REQ));
      stall_expired = TIMEOUT_EN && (state_q == ST_LOCKED) && !g_valid && (cnt_q == CNT_LIMIT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         rr_ptr_q        <= '0;
         gidx_q          <= '0;
         grant_q         <= '0;
         cnt_q           <= '0;
         timeout_pulse_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         rr_ptr_q        <= rr_ptr_d;
         gidx_q          <= gidx_d;
         grant_q         <= grant_d;
         cnt_q           <= cnt_d;
         timeout_pulse_q <= timeout_pulse_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      rr_ptr_d        = rr_ptr_q;
      gidx_d          = gidx_q;
      grant_d         = grant_q;
      cnt_d           = cnt_q;
      timeout_pulse_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d = ST_LOCKED;
               grant_d = pick_onehot;
               gidx_d  = pick_idx;
               cnt_d   = '0;
            end
         end
         ST_LOCKED: begin
            // A presented byte always wins over the stall timer, even when tx is busy.
            if (g_valid) begin
               cnt_d = '0;
               if (tx_ready && g_last) begin
                  state_d  = ST_IDLE;
                  grant_d  = '0;
                  rr_ptr_d = next_ptr;
               end
            end else if (stall_expired) begin
               state_d         = ST_IDLE;
               grant_d         = '0;
               rr_ptr_d        = next_ptr;
               cnt_d           = '0;
               timeout_pulse_d = 1'b1;
            end else if (TIMEOUT_EN) begin
               cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_comb begin
      tx_valid  = 1'b0;
      tx_data   = '0;
      req_ready = '0;
      if (state_q == ST_LOCKED) begin
         tx_valid  = g_valid;
         tx_data   = g_data;
         req_ready = grant_q & {NUM_REQ{tx_ready}};
      end
   end

   assign grant         = grant_q;
   assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a 2-requester instance against a message-level model, plus a 3-requester wrap check.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int N = 2;
   localparam int T = 8;

   localparam logic [1:0] EXP_GA [8] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
   localparam logic [2:0] EXP_GB [8] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
   localparam logic [1:0] EXP_RR [12] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01,
                                          2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
   localparam logic [7:0] EXP_RR_TX [6] = '{8'h10, 8'h20, 8'h10, 8'h20, 8'h10, 8'h20};
   localparam logic [1:0] EXP_TO_G [13] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                                            2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset = 1'b1;
   logic         reset_nxt = 1'b1;
   logic [15:0]  a_data = '0;
   logic [N-1:0] a_valid = '0;
   logic [N-1:0] a_last = '0;
   logic [N-1:0] a_ready;
   logic [7:0]   a_tx_data;
   logic         a_tx_valid;
   logic         a_tx_ready = 1'b1;
   logic         tx_ready_nxt = 1'b1;
   logic [N-1:0] a_grant;
   logic         a_pulse;

   logic [23:0]  b_data = 24'hA2A1A0;
   logic [2:0]   b_valid = 3'b111;
   logic [2:0]   b_last = 3'b111;
   logic [2:0]   b_ready;
   logic [7:0]   b_tx_data;
   logic         b_tx_valid;
   logic         b_tx_ready = 1'b1;
   logic [2:0]   b_grant;
   logic         b_pulse;

   uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(4)) dut_a (
      .clk(clk), .reset(reset), .req_data(a_data), .req_valid(a_valid), .req_last(a_last),
      .req_ready(a_ready), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
      .grant(a_grant), .timeout_pulse(a_pulse)
   );

   uart_tx_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(4)) dut_b (
      .clk(clk), .reset(reset), .req_data(b_data), .req_valid(b_valid), .req_last(b_last),
      .req_ready(b_ready), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
      .grant(b_grant), .timeout_pulse(b_pulse)
   );

   // Per-requester message queues {last, byte}; the driver walks them with read indices.
   logic [8:0]   q0 [$];
   logic [8:0]   q1 [$];
   int           rd0 = 0;
   int           rd1 = 0;
   logic [N-1:0] fire_a = '0;
   logic [7:0]   txlog [$];

   int passed = 0;
   int total  = 0;

   // Model state: who holds the transmitter, where the next search starts, stall length.
   bit m_locked = 1'b0;
   int m_owner  = 0;
   int m_ptr    = 0;
   int m_stall  = 0;
   bit m_pulse  = 1'b0;

   always @(posedge clk) begin
      #1;
      reset      = reset_nxt;
      a_tx_ready = tx_ready_nxt;
      if (fire_a[0]) rd0++;
      if (fire_a[1]) rd1++;
      a_valid[0]    = (rd0 < q0.size());
      a_last[0]     = (rd0 < q0.size()) ? q0[rd0][8] : 1'b0;
      a_data[7:0]   = (rd0 < q0.size()) ? q0[rd0][7:0] : 8'h00;
      a_valid[1]    = (rd1 < q1.size());
      a_last[1]     = (rd1 < q1.size()) ? q1[rd1][8] : 1'b0;
      a_data[15:8]  = (rd1 < q1.size()) ? q1[rd1][7:0] : 8'h00;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_check();
      logic       ev;
      logic [7:0] ed;
      logic [1:0] eg;
      logic [1:0] er;
      eg = '0;
      if (m_locked) eg[m_owner] = 1'b1;
      ev = m_locked && a_valid[m_owner];
      ed = m_locked ? a_data[8*m_owner +: 8] : 8'h00;
      er = (m_locked && a_tx_ready) ? eg : 2'b00;
      chk("model_tx_valid", a_tx_valid, ev);
      chk("model_tx_data", a_tx_data, ed);
      chk("model_grant", a_grant, eg);
      chk("model_req_ready", a_ready, er);
      chk("model_timeout_pulse", a_pulse, m_pulse);
   endtask

   task automatic model_advance();
      m_pulse = 1'b0;
      if (reset) begin
         m_locked = 1'b0;
         m_ptr    = 0;
         m_stall  = 0;
      end else if (!m_locked) begin
         for (int k = 0; k < N; k++) begin
            if (!m_locked && a_valid[(m_ptr + k) % N]) begin
               m_locked = 1'b1;
               m_owner  = (m_ptr + k) % N;
               m_stall  = 0;
            end
         end
      end else if (a_valid[m_owner]) begin
         m_stall = 0;
         if (a_tx_ready && a_last[m_owner]) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % N;
         end
      end else begin
         m_stall++;
         if (m_stall == T) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % N;
            m_pulse  = 1'b1;
            m_stall  = 0;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_check();
      fire_a = a_valid & a_ready;
      if (a_tx_valid && a_tx_ready) txlog.push_back(a_tx_data);
      model_advance();
      #1;
   endtask

   task automatic push0(input logic [7:0] d, input logic l);
      q0.push_back({l, d});
   endtask

   task automatic push1(input logic [7:0] d, input logic l);
      q1.push_back({l, d});
   endtask

   function automatic bit a_idle();
      return (rd0 >= q0.size()) && (rd1 >= q1.size()) && (a_grant == 2'b00);
   endfunction

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!a_idle() && n < 100) begin
         step();
         n++;
      end
      chk(name, a_idle(), 1);
   endtask

   initial begin
      logic [1:0] ga [8];
      logic [2:0] gb [8];
      logic [1:0] gr [13];
      logic       pr [13];
      int         lb;
      int         bad;
      int         n;
      int         pulses;

      // Reset with traffic already pending: "AB" from req0, "Z" from req1.
      push0(8'h41, 1'b0);
      push0(8'h42, 1'b1);
      push1(8'h5A, 1'b1);
      step();
      chk("rst_valid_pending", a_valid, 2'b11);
      chk("rst_tx_valid", a_tx_valid, 0);
      chk("rst_grant", a_grant, 0);
      chk("rst_req_ready", a_ready, 0);
      chk("rst_tx_data", a_tx_data, 0);
      chk("rst_b_grant", b_grant, 0);
      reset_nxt = 1'b0;

      bad = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         ga[k] = a_grant;
         gb[k] = b_grant;
         if (a_grant == 2'b01 && a_ready[1]) bad++;
      end
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("lock_grant[%0d]", k), ga[k], EXP_GA[k]);
         chk($sformatf("wrap3_grant[%0d]", k), gb[k], EXP_GB[k]);
      end
      chk("lock_req1_ready_during_req0", bad, 0);
      chk("lock_tx_count", txlog.size(), 3);
      if (txlog.size() == 3) begin
         chk("lock_tx0", txlog[0], 8'h41);
         chk("lock_tx1", txlog[1], 8'h42);
         chk("lock_tx2", txlog[2], 8'h5A);
      end

      // Round robin with back-to-back single-byte messages.
      wait_idle("rr_drain_before");
      lb = txlog.size();
      for (int k = 0; k < 3; k++) begin
         push0(8'h10, 1'b1);
         push1(8'h20, 1'b1);
      end
      for (int k = 0; k < 12; k++) begin
         step();
         gr[k] = a_grant;
      end
      for (int k = 0; k < 12; k++) chk($sformatf("rr_grant[%0d]", k), gr[k], EXP_RR[k]);
      chk("rr_tx_count", txlog.size() - lb, 6);
      if (txlog.size() - lb == 6) begin
         for (int k = 0; k < 6; k++) chk($sformatf("rr_tx[%0d]", k), txlog[lb + k], EXP_RR_TX[k]);
      end

      // Transmitter stalls 50 cycles mid-message with the holder still valid.
      wait_idle("bp_drain_before");
      lb = txlog.size();
      push0(8'h61, 1'b0);
      push0(8'h62, 1'b0);
      push0(8'h63, 1'b1);
      n = 0;
      while (txlog.size() == lb && n < 20) begin
         step();
         n++;
      end
      chk("bp_first_byte_sent", txlog.size() - lb, 1);
      tx_ready_nxt = 1'b0;
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         step();
         if (a_tx_data != 8'h62 || !a_tx_valid || a_pulse || a_ready != 2'b00) bad++;
      end
      chk("bp_hold_stable", bad, 0);
      tx_ready_nxt = 1'b1;
      step();
      chk("bp_accept_ready", a_ready, 2'b01);
      chk("bp_accept_count", txlog.size() - lb, 2);
      wait_idle("bp_drain_after");
      chk("bp_tx_count", txlog.size() - lb, 3);
      if (txlog.size() - lb == 3) begin
         chk("bp_tx0", txlog[lb], 8'h61);
         chk("bp_tx1", txlog[lb + 1], 8'h62);
         chk("bp_tx2", txlog[lb + 2], 8'h63);
      end

      // req1 abandons its message after one byte; req0 waits behind the lock.
      wait_idle("to_drain_before");
      lb = txlog.size();
      push1(8'h33, 1'b0);
      push0(8'h44, 1'b1);
      pulses = 0;
      for (int k = 0; k < 13; k++) begin
         step();
         gr[k] = a_grant;
         pr[k] = a_pulse;
         if (a_pulse) pulses++;
      end
      for (int k = 0; k < 13; k++) chk($sformatf("to_grant[%0d]", k), gr[k], EXP_TO_G[k]);
      chk("to_pulse_at_release", pr[10], 1);
      chk("to_pulse_count", pulses, 1);
      chk("to_tx_count", txlog.size() - lb, 2);
      if (txlog.size() - lb == 2) begin
         chk("to_tx0", txlog[lb], 8'h33);
         chk("to_tx1", txlog[lb + 1], 8'h44);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
